// File: rtl/scramble_pkg.sv
// scramble_pkg: definitions shared by the scramble/descramble pair so both
// directions stay bit-exact.
//   DEF_AW / DEF_KW : default address / key widths (12 / 16)
//   state_t         : controller states
//   rotl16          : 16-bit rotate left
//   round_f         : round function F(x,k) = ((x ^ k[5:0]) + k[11:6]) mod 64
//   round_key       : k_r = rotl16(key, 3r mod 16)[11:0]
//   round_count     : N = key[15:12] + 1
package scramble_pkg;

    localparam int DEF_AW = 12;
    localparam int DEF_KW = 16;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_ROUND = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    function automatic logic [15:0] rotl16(input logic [15:0] v, input logic [3:0] s);
        logic [31:0] d;
        d = {v, v} << s;
        return d[31:16];
    endfunction

    // 6-bit add; the carry out is intentionally dropped.
    function automatic logic [5:0] round_f(input logic [5:0] x, input logic [11:0] k);
        return (x ^ k[5:0]) + k[11:6];
    endfunction

    function automatic logic [11:0] round_key(input logic [15:0] key, input logic [3:0] r);
        logic [15:0] t;
        t = rotl16(key, 4'(3 * r));
        return t[11:0];
    endfunction

    function automatic logic [4:0] round_count(input logic [15:0] key);
        return {1'b0, key[15:12]} + 5'd1;
    endfunction

endpackage

// File: rtl/descramble_if.sv
// descramble_if: request/result bundle of the descrambler.
//   start     : request strobe (master -> slave)
//   in_addr   : scrambled window address (master -> slave)
//   key       : 16-bit key (master -> slave)
//   busy      : operation in progress (slave -> master)
//   out_valid : one-cycle result strobe (slave -> master)
//   out_addr  : descrambled address, held until the next result (slave -> master)
interface descramble_if
    import scramble_pkg::*;
#(
    parameter int AW = DEF_AW,
    parameter int KW = DEF_KW
);
    logic          start;
    logic [AW-1:0] in_addr;
    logic [KW-1:0] key;
    logic          busy;
    logic          out_valid;
    logic [AW-1:0] out_addr;

    modport master (
        output start, in_addr, key,
        input  busy, out_valid, out_addr
    );

    modport slave (
        input  start, in_addr, key,
        output busy, out_valid, out_addr
    );
endinterface

// File: rtl/descramble_round.sv
// descramble_round: one combinational inverse Feistel round.
//   l_in, r_in : current halves (L', R')
//   rk         : 12-bit round key k_r
//   l_out      : R' ^ F(L', k_r)
//   r_out      : L'
module descramble_round
    import scramble_pkg::*;
#(
    parameter int HW = DEF_AW / 2
) (
    input  logic [HW-1:0]   l_in,
    input  logic [HW-1:0]   r_in,
    input  logic [2*HW-1:0] rk,
    output logic [HW-1:0]   l_out,
    output logic [HW-1:0]   r_out
);
    always_comb begin
        l_out = r_in ^ round_f(l_in, rk);
        r_out = l_in;
    end
endmodule

// File: rtl/descramble.sv
// descramble: iterative inverse address permutation for the 64x64 face
// window, one inverse Feistel round per clock, rounds N-1 down to 0.
//   clk   : rising-edge clock
//   reset : synchronous, active-high
//   bus   : descramble_if slave (start/in_addr/key in, busy/out_valid/out_addr out)
// Build option: DESCRAMBLE_FIXED_ROUNDS_EN -> N = FIXED_ROUNDS for every key;
// otherwise N = key[15:12] + 1.
module descramble
    import scramble_pkg::*;
#(
    parameter int AW           = DEF_AW,
    parameter int KW           = DEF_KW,
    parameter int FIXED_ROUNDS = 12
) (
    input  logic clk,
    input  logic reset,
    descramble_if.slave bus
);
    localparam int HW = AW / 2;
    // Counter holds N-1: 4 bits cover the key-driven range, wider only if
    // a larger fixed round count is configured.
    localparam int CW = ($clog2(FIXED_ROUNDS) > 4) ? $clog2(FIXED_ROUNDS) : 4;

    state_t        state, state_next;
    logic [AW-1:0] lr_q;
    logic [AW-1:0] out_addr_q;
    logic [KW-1:0] key_q;
    logic [KW-1:0] wkey_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] last_round;
    logic [HW-1:0] l_new, r_new;

    always_comb begin
`ifdef DESCRAMBLE_FIXED_ROUNDS_EN
        last_round = CW'(FIXED_ROUNDS - 1);
`else
        last_round = CW'(round_count(key_q) - 5'd1);
`endif
    end

    descramble_round #(.HW(HW)) u_round (
        .l_in  (lr_q[AW-1:HW]),
        .r_in  (lr_q[HW-1:0]),
        .rk    (wkey_q[2*HW-1:0]),
        .l_out (l_new),
        .r_out (r_new)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            lr_q       <= '0;
            out_addr_q <= '0;
            key_q      <= '0;
            wkey_q     <= '0;
            cnt_q      <= '0;
        end else begin
            state <= state_next;
            case (state)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        lr_q  <= bus.in_addr;
                        key_q <= bus.key;
                    end
                end
                S_LOAD: begin
                    // Start from the last round key; each round then steps
                    // the rotation back by 3 instead of recomputing it.
                    cnt_q  <= last_round;
                    wkey_q <= rotl16(key_q, 4'(3 * last_round));
                end
                S_ROUND: begin
                    lr_q   <= {l_new, r_new};
                    wkey_q <= rotl16(wkey_q, 4'd13);
                    cnt_q  <= cnt_q - CW'(1);
                    if (cnt_q == '0) begin
                        out_addr_q <= {l_new, r_new};
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next    = state;
        bus.busy      = 1'b0;
        bus.out_valid = 1'b0;
        bus.out_addr  = out_addr_q;
        case (state)
            S_IDLE: begin
                if (bus.start) state_next = S_LOAD;
            end
            S_LOAD: begin
                bus.busy   = 1'b1;
                state_next = S_ROUND;
            end
            S_ROUND: begin
                bus.busy = 1'b1;
                if (cnt_q == '0) state_next = S_DONE;
            end
            S_DONE: begin
                bus.out_valid = 1'b1;
                state_next    = bus.start ? S_LOAD : S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_descramble.sv
// tb_descramble: randomized and directed checks of descramble against an
// arithmetic reference model of the forward and inverse Feistel network.
module tb_descramble;
    localparam int AW = 12;
    localparam int KW = 16;
`ifdef DESCRAMBLE_FIXED_ROUNDS_EN
    localparam int FR = 4;
`else
    localparam int FR = 12;
`endif

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    descramble_if #(.AW(AW), .KW(KW)) dif ();

    descramble #(.AW(AW), .KW(KW), .FIXED_ROUNDS(FR)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (dif)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit seen [4096];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int rounds_of(input int key);
`ifdef DESCRAMBLE_FIXED_ROUNDS_EN
        return FR;
`else
        return ((key >> 12) & 15) + 1;
`endif
    endfunction

    function automatic int rkey(input int key, input int r);
        int s;
        int rot;
        s   = (3 * r) % 16;
        rot = ((key << s) | (key >> (16 - s))) & 'hFFFF;
        return rot & 'hFFF;
    endfunction

    function automatic int ff(input int x, input int k);
        return ((x ^ (k & 63)) + ((k >> 6) & 63)) % 64;
    endfunction

    function automatic int scramble_m(input int a, input int key);
        int l, r, t;
        l = (a >> 6) & 63;
        r = a & 63;
        for (int i = 0; i < rounds_of(key); i++) begin
            t = l ^ ff(r, rkey(key, i));
            l = r;
            r = t;
        end
        return l * 64 + r;
    endfunction

    function automatic int descr_m(input int a, input int key);
        int l, r, t;
        l = (a >> 6) & 63;
        r = a & 63;
        for (int i = rounds_of(key) - 1; i >= 0; i--) begin
            t = r ^ ff(l, rkey(key, i));
            r = l;
            l = t;
        end
        return l * 64 + r;
    endfunction

    // Called at a negedge with the DUT in IDLE or DONE. lat counts edges from
    // the accepting edge to the one that raises out_valid.
    task automatic run_one(input int a, input int k, input bit keep_start,
                           output int lat, output int res, output int busy_cyc);
        dif.start   = 1'b1;
        dif.in_addr = 12'(a);
        dif.key     = 16'(k);
        @(posedge clk);
        lat      = 0;
        busy_cyc = 0;
        res      = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!keep_start) dif.start = 1'b0;
            if (dif.busy) busy_cyc++;
            if (dif.out_valid) begin
                res = int'(dif.out_addr);
                break;
            end
            lat++;
        end
    endtask

    initial begin
        int lat, res, bc, a, k, pulses, uniq, exp1;

        reset       = 1'b1;
        dif.start   = 1'b0;
        dif.in_addr = '0;
        dif.key     = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 32'(dif.busy), 0);
        check("rst_valid", 32'(dif.out_valid), 0);
        check("rst_addr", 32'(dif.out_addr), 0);
        reset = 1'b0;
        @(negedge clk);

        // Minimal-round directed cases
`ifdef DESCRAMBLE_FIXED_ROUNDS_EN
        exp1 = descr_m('h041, 0);
`else
        exp1 = 'h001;
`endif
        run_one('h041, 'h0000, 1'b0, lat, res, bc);
        check("k0_addr", res, exp1);
        check("k0_lat", lat, rounds_of(0) + 1);
        check("k0_busy", bc, rounds_of(0) + 1);
        @(negedge clk);
        check("k0_pulse_once", 32'(dif.out_valid), 0);
        check("k0_hold", 32'(dif.out_addr), exp1);

`ifdef DESCRAMBLE_FIXED_ROUNDS_EN
        exp1 = descr_m(0, 3);
`else
        exp1 = 'h0C0;
`endif
        run_one('h000, 'h0003, 1'b0, lat, res, bc);
        check("k3_addr", res, exp1);
        check("k3_lat", lat, rounds_of(3) + 1);
        @(negedge clk);

        // Random single requests
        for (int i = 0; i < 30; i++) begin
            a = int'($urandom_range(0, 4095));
            k = int'($urandom & 32'hFFFF);
            run_one(a, k, 1'b0, lat, res, bc);
            check("rnd_addr", res, descr_m(a, k));
            check("rnd_lat", lat, rounds_of(k) + 1);
            @(negedge clk);
        end

        // Fixed-round-style key
        a = int'($urandom_range(0, 4095));
        run_one(a, 'hF123, 1'b0, lat, res, bc);
        check("f123_addr", res, descr_m(a, 'hF123));
        check("f123_lat", lat, rounds_of('hF123) + 1);
        @(negedge clk);

        // Full window, back-to-back, key B530
        for (int i = 0; i < 4096; i++) seen[i] = 1'b0;
        for (int i = 0; i < 4096; i++) begin
            run_one(scramble_m(i, 'hB530), 'hB530, 1'b1, lat, res, bc);
            check("b2b_addr", res, i);
            check("b2b_lat", lat, rounds_of('hB530) + 1);
            if (res >= 0 && res < 4096) begin
                check("b2b_dup", 32'(seen[res]), 0);
                seen[res] = 1'b1;
            end
        end
        dif.start = 1'b0;
        uniq = 0;
        for (int i = 0; i < 4096; i++) if (seen[i]) uniq++;
        check("b2b_bijection", uniq, 4096);
        @(negedge clk);
        @(negedge clk);

        // start and key disturbed mid-operation
        a = int'($urandom_range(0, 4095));
        k = 'hB530;
        dif.start   = 1'b1;
        dif.in_addr = 12'(a);
        dif.key     = 16'(k);
        @(posedge clk);
        pulses = 0;
        res    = -1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (i == 0) dif.start = 1'b0;
            if (i == 3) begin
                dif.start   = 1'b1;
                dif.key     = 16'($urandom);
                dif.in_addr = 12'($urandom);
            end
            if (i == 4) dif.start = 1'b0;
            if (dif.out_valid) begin
                pulses++;
                if (pulses == 1) res = int'(dif.out_addr);
            end
        end
        check("midop_pulses", pulses, 1);
        check("midop_addr", res, descr_m(a, k));

        // Reset in the middle of an operation
        a = int'($urandom_range(0, 4095));
        dif.start   = 1'b1;
        dif.in_addr = 12'(a);
        dif.key     = 16'hB530;
        @(posedge clk);
        @(negedge clk);
        dif.start = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midrst_busy", 32'(dif.busy), 0);
        check("midrst_valid", 32'(dif.out_valid), 0);
        check("midrst_addr", 32'(dif.out_addr), 0);
        reset  = 1'b0;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (dif.out_valid) pulses++;
        end
        check("midrst_nopulse", pulses, 0);
        a = int'($urandom_range(0, 4095));
        run_one(a, 'hB530, 1'b0, lat, res, bc);
        check("postrst_addr", res, descr_m(a, 'hB530));
        check("postrst_lat", lat, rounds_of('hB530) + 1);
        @(negedge clk);

        // reset and start on the same edge
        reset     = 1'b1;
        dif.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rststart_busy", 32'(dif.busy), 0);
        reset     = 1'b0;
        dif.start = 1'b0;
        @(negedge clk);
        check("rststart_dropped", 32'(dif.busy), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/descramble.md
# descramble

Key-driven inverse address permutation for the 64×64 face window of the 256×256 gray image. Given a scrambled 12-bit window address and the 16-bit key, it iterates the inverse Feistel rounds of the scrambler, one round per clock. It returns the original address so the image pipeline can restore a scrambled face region pixel by pixel. It is the receive-side counterpart of `scramble` and shares its round definitions.

## Interface
- `AW`, 12: address width; must be even, with halves row = `addr[AW-1:AW/2]` and col = `addr[AW/2-1:0]`.
- `KW`, 16: key width.
- `FIXED_ROUNDS`, 12: round count, used only under the configuration macro.
- `clk`, in, 1: single clock, rising edge.
- `reset`, in, 1: synchronous, active-high.
- `start`, in, 1: request strobe; sampled only in IDLE or DONE.
- `in_addr`, in, AW: scrambled address; captured on the accepting edge.
- `key`, in, KW: key; captured on the accepting edge.
- `busy`, out, 1: high in LOAD/ROUND.
- `out_valid`, out, 1: one-cycle pulse when `out_addr` becomes valid.
- `out_addr`, out, AW: descrambled address; holds until the next result.

## Operation
- Forward scramble round r maps (L,R) to (R, L ^ F(R,k_r)). The descrambler applies the inverse round, (L',R') to (R' ^ F(L',k_r), L'), for r = N-1 down to 0.
- F(x,k) = ((x ^ k[5:0]) + k[11:6]) mod 64, a 6-bit add with carry-out discarded.
- k_r = rotl16(key, (3·r) mod 16)[11:0].
- N = `key[15:12]` + 1, giving 1..16 rounds.
- The round key is generated incrementally. LOAD forms rotl16(key, 3(N-1) mod 16); each ROUND rotates the working key right by 3.
- States:
  - IDLE: wait for `start`.
  - LOAD: capture inputs, set round counter to N-1, form the first round key.
  - ROUND: one inverse round per cycle; the counter decrements.
  - DONE: `out_valid` = 1.
- Transitions:
  - IDLE goes to LOAD on `start`.
  - LOAD goes to ROUND.
  - ROUND goes to DONE after the round with counter 0.
  - DONE goes to LOAD if `start`, else to IDLE.
- `start` in LOAD/ROUND is ignored. It is not queued.
- A key change while busy has no effect, because the key is already captured.

## Timing
- Reset values: state IDLE, `busy` 0, `out_valid` 0, `out_addr` 0, internal registers 0.
- Edge t accepts `start` and enters LOAD. Edges t+1 .. t+N perform the N rounds. Edge t+N+1 enters DONE with `out_addr` updated and `out_valid` = 1 for exactly one cycle.
- Latency is therefore N+1 cycles from the accepting edge to `out_valid` high. N = 1 gives 2 cycles; key 16'hB530 gives N = 12 and 13 cycles.
- Back-to-back: `start` during DONE is accepted at that edge. Throughput is one result per N+1 cycles; no idle cycle is inserted.
- `reset` asserted in any state returns all outputs to reset values on that edge. A partial result is discarded with no `out_valid`.
- `reset` and `start` asserted on the same edge: reset wins and `start` is dropped.

## Configuration
- `DESCRAMBLE_FIXED_ROUNDS_EN` defined: N = `FIXED_ROUNDS` for every key, and `key[15:12]` only feeds the round-key bits.
- Undefined: N = `key[15:12]` + 1 as above.
- The forward scrambler must be built with the same setting.

## Structure
- Shared package `scramble_pkg` holds:
  - `AW`/`KW` defaults;
  - the state enum;
  - functions `round_f(x,k)`, `round_key(key,r)` and `round_count(key)`.
- These are shared with `scramble` so both directions stay bit-exact.
- One sub-module, `descramble_round`: combinational single inverse round (L',R',k) to (L,R). It is instantiated once and fed from the state registers.

## Test plan
- Reset then key 16'h0000, `in_addr` 12'h041, `start` → `out_addr` 12'h001, `out_valid` at accept+2, `busy` high 2 cycles.
- Key 16'h0003, `in_addr` 12'h000 → `out_addr` 12'h0C0.
- Key 16'hB530: forward-model scramble each of the 4096 addresses, feed them back-to-back → every result equals the original, each `out_valid` exactly 13 cycles after its accept, and outputs form a bijection.
- `start` pulsed during ROUND, with `key` changed mid-operation → result unchanged, second `start` ignored, exactly one `out_valid`.
- `reset` asserted at round 5 of 12 → next edge `busy`/`out_valid`/`out_addr` = 0/0/0, no pulse afterwards; a fresh request then completes normally.
- With `DESCRAMBLE_FIXED_ROUNDS_EN`, `FIXED_ROUNDS` = 4, key 16'hF123 → `out_valid` at accept+5 and result matches the 4-round forward model.
